writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 Parameter DEPTH, default 2, buffer entries; power of two, at least 2.
REQ-003 Parameter REGW, default 5, register index width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream presents a retiring instruction.
REQ-007 in_ready  out  1  queue accepts this cycle.
REQ-008 in_wen  in  1  instruction writes a register.
REQ-009 in_dst  in  REGW  destination register.
REQ-010 in_data  in  XLEN  ALU result or raw memory read word.
REQ-011 in_mem  in  1  in_data is load data needing extraction.
REQ-012 in_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword.
REQ-013 in_unsigned  in  1  zero-extend load (else sign-extend).
REQ-014 in_addr_lo  in  3  load byte offset within the dword.
REQ-015 rf_ready  in  1  register-file write port free this cycle.
REQ-016 rf_wen  out  1  register-file write enable.
REQ-017 rf_dst  out  REGW  write index.
REQ-018 rf_wdata  out  XLEN  write data.
REQ-019 commit_cnt  out  32  retired-instruction count.
REQ-020 fwd_rs  in  REGW  forwarding query index.
REQ-021 fwd_hit  out  1  a queued entry produces fwd_rs.
REQ-022 fwd_data  out  XLEN  forwarded value.

Function
REQ-023 The block SHALL hold a circular FIFO of DEPTH entries {wen, dst, data} with head/tail pointers and an occupancy count of 0..DEPTH.
REQ-024 Push SHALL occur when in_valid && in_ready; in_ready = (count < DEPTH) && !reset; no pass-through when full, even if a pop occurs that cycle.
REQ-025 Load extraction SHALL happen before storage: shift in_data right by 8*in_addr_lo, keep 8/16/32/64 bits per in_size, extend per in_unsigned; in_addr_lo bits below size alignment SHALL be ignored (forced to 0); in_mem=0 stores in_data unchanged.
REQ-026 Stored wen SHALL be in_wen && (in_dst != 0); x0 is never written.
REQ-027 Pop SHALL occur when count > 0 && rf_ready; rf_wen = pop && head.wen; rf_dst/rf_wdata driven from the head entry and 0 when count = 0.
REQ-028 Latency SHALL be one cycle minimum: entry pushed at edge N appears on rf_* in cycle N+1.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-030 commit_cnt SHALL increment by 1 on every pop regardless of wen, wrapping from 0xFFFFFFFF to 0.
REQ-031 Order SHALL be preserved: entries reach rf_* strictly in push order.

Reset
REQ-032 While reset is high at an edge: count, pointers and commit_cnt SHALL become 0; entries SHALL be discarded, including mid-stream; rf_wen, fwd_hit SHALL be 0; in_ready SHALL be 0 during reset and 1 in the first cycle after.

Configuration
REQ-033 Macro WRITEBACK_QUEUE_FORWARD_EN: when defined, fwd_hit=1 iff some occupied entry has wen=1 and dst==fwd_rs (fwd_rs != 0), with fwd_data from the youngest match, combinational with respect to queue state; when undefined, fwd_hit and fwd_data SHALL be constant 0 with no compare logic, ports retained.

Verification
REQ-034 Reset, then push {wen=1,dst=3,data=0x1234}, rf_ready=1 -> next cycle rf_wen=1, rf_dst=3, rf_wdata=0x1234, commit_cnt=1.
REQ-035 Load in_data=0x00000000_80FF0000, in_mem=1, size=0, addr_lo=2, signed -> rf_wdata=0xFFFFFFFF_FFFFFFFF; same with in_unsigned=1 -> 0xFF; size=1, addr_lo=3 -> offset forced to 2, extracts 0x80FF, signed gives 0xFFFFFFFF_FFFF80FF.
REQ-036 rf_ready=0, push DEPTH=2 entries -> in_ready=0, third in_valid held; raise rf_ready -> entries drain in order, held entry accepted only after count drops.
REQ-037 Push dst=0 wen=1 -> rf_wen stays 0, commit_cnt still increments.
REQ-038 With forward enabled, queue dst=5 data=0xA then dst=5 data=0xB, rf_ready=0, fwd_rs=5 -> fwd_hit=1, fwd_data=0xB; fwd_rs=0 -> fwd_hit=0; without macro -> fwd_hit=0.
REQ-039 Assert reset with 2 entries queued -> next cycle count=0, rf_wen=0, commit_cnt=0, nothing written afterwards.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: in-order FIFO between retire and register-file write port, with load extraction.
// Optional forwarding of queued results is enabled by defining WRITEBACK_QUEUE_FORWARD_EN.
module writeback_queue #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 2,
   parameter int REGW  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_wen,
   input  logic [REGW-1:0] in_dst,
   input  logic [XLEN-1:0] in_data,
   input  logic            in_mem,
   input  logic [1:0]      in_size,
   input  logic            in_unsigned,
   input  logic [2:0]      in_addr_lo,
   input  logic            rf_ready,
   output logic            rf_wen,
   output logic [REGW-1:0] rf_dst,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     commit_cnt,
   input  logic [REGW-1:0] fwd_rs,
   output logic            fwd_hit,
   output logic [XLEN-1:0] fwd_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic            mem_wen  [DEPTH];
   logic [REGW-1:0] mem_dst  [DEPTH];
   logic [XLEN-1:0] mem_data [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          empty;
   logic          push;
   logic          pop;
   logic [XLEN-1:0] store_data;
   logic            store_wen;

   // Offset bits below the access alignment are dropped before shifting.
   function automatic logic [XLEN-1:0] extract_load(
      input logic [XLEN-1:0] d,
      input logic [1:0]      size,
      input logic            uns,
      input logic [2:0]      lo
   );
      logic [2:0]      off;
      logic [XLEN-1:0] sh;
      logic signed [7:0]  b8;
      logic signed [15:0] h16;
      logic signed [31:0] w32;
      logic [XLEN-1:0] res;
      case (size)
         2'd0:    off = lo;
         2'd1:    off = {lo[2:1], 1'b0};
         2'd2:    off = {lo[2], 2'b00};
         default: off = 3'd0;
      endcase
      sh  = d >> {off, 3'b000};
      b8  = sh[7:0];
      h16 = sh[15:0];
      w32 = sh[31:0];
      case (size)
         2'd0:    res = {{(XLEN-8){b8[7] & ~uns}}, b8};
         2'd1:    res = {{(XLEN-16){h16[15] & ~uns}}, h16};
         2'd2:    res = {{(XLEN-32){w32[31] & ~uns}}, w32};
         default: res = sh;
      endcase
      return res;
   endfunction

   assign empty      = (count == '0);
   assign in_ready   = (count != FULL) && !reset;
   assign push       = in_valid && in_ready;
   assign pop        = !empty && rf_ready && !reset;
   assign store_data = in_mem ? extract_load(in_data, in_size, in_unsigned, in_addr_lo) : in_data;
   assign store_wen  = in_wen && (in_dst != '0);

   assign rf_wen   = pop && mem_wen[head];
   assign rf_dst   = empty ? '0 : mem_dst[head];
   assign rf_wdata = empty ? '0 : mem_data[head];

   // Entry payload carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wen[tail]  <= store_wen;
         mem_dst[tail]  <= in_dst;
         mem_data[tail] <= store_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         commit_cnt <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) begin
            head       <= head + 1'b1;
            commit_cnt <= commit_cnt + 32'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef WRITEBACK_QUEUE_FORWARD_EN
   logic            hit;
   logic [XLEN-1:0] hit_data;
   logic [PW-1:0]   idx;

   // Scan oldest to youngest so the last match found is the youngest producer.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && mem_wen[idx] && (mem_dst[idx] == fwd_rs) && (fwd_rs != '0)) begin
            hit      = 1'b1;
            hit_data = mem_data[idx];
         end
      end
   end

   assign fwd_hit  = hit && !reset;
   assign fwd_data = hit_data;
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_rs;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule
